// File: rtl/hid_keycode_writer.sv
// HID boot-keyboard report receiver: validates each 8-byte report and compacts
// its key slots into four keycode registers, optionally released on frame sync.
module hid_keycode_writer #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit FRAME_ALIGN    = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    input  logic       frame_sync,
    output logic [7:0] keycode0,
    output logic [7:0] keycode1,
    output logic [7:0] keycode2,
    output logic [7:0] keycode3,
    output logic [7:0] modifier,
    output logic       report_strobe,
    output logic       rollover_drop,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } state_t;

    localparam logic [15:0] GAP_MAX = 16'(TIMEOUT_CYCLES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_idx;
    logic [15:0]     r_gap;
    logic [7:0]      r_mod_in;
    logic [5:0][7:0] r_key;
    logic [3:0][7:0] r_pend;
    logic [7:0]      r_pend_mod;
    logic            r_pend_valid;
    logic [3:0][7:0] r_kc;
    logic [7:0]      r_mod;
    logic            r_fs_d;
    logic            r_strobe;
    logic            r_roll;
    logic            r_tmo;

    logic            w_xfer;
    logic            w_timeout;
    logic            w_roll;
    logic            w_commit_ok;
    logic            w_frame_edge;
    logic [3:0][7:0] w_slot;
    logic [2:0]      w_n;

    assign byte_ready   = Reset && (r_state != COMMIT);
    assign w_xfer       = byte_valid && byte_ready;
    assign w_frame_edge = frame_sync && !r_fs_d;
    assign w_commit_ok  = (r_state == COMMIT) && !w_roll;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) w_next = COLLECT;
            end
            COLLECT: begin
                if (w_xfer && r_idx == 3'd7) begin
                    w_next = COMMIT;
                end else if (!w_xfer && r_gap == GAP_MAX) begin
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            COMMIT: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Pack nonzero keys in arrival order; any ErrorRollOver code poisons the report.
    always_comb begin
        w_slot = '0;
        w_n    = 3'd0;
        w_roll = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (r_key[k] == 8'h01) w_roll = 1'b1;
            if (r_key[k] != 8'h00 && w_n < 3'd4) begin
                w_slot[w_n[1:0]] = r_key[k];
                w_n              = w_n + 3'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_idx        <= 3'd0;
            r_gap        <= 16'd0;
            r_mod_in     <= 8'h00;
            r_key        <= '0;
            r_pend       <= '0;
            r_pend_mod   <= 8'h00;
            r_pend_valid <= 1'b0;
            r_kc         <= '0;
            r_mod        <= 8'h00;
            r_fs_d       <= 1'b0;
            r_strobe     <= 1'b0;
            r_roll       <= 1'b0;
            r_tmo        <= 1'b0;
        end else begin
            r_fs_d   <= frame_sync;
            r_strobe <= 1'b0;
            r_roll   <= (r_state == COMMIT) && w_roll;
            r_tmo    <= w_timeout;

            if (r_state == COLLECT && !w_xfer && !w_timeout) begin
                r_gap <= r_gap + 16'd1;
            end else begin
                r_gap <= 16'd0;
            end

            if (w_xfer) begin
                if (r_state == IDLE) begin
                    r_mod_in <= byte_data;
                    r_idx    <= 3'd1;
                end else begin
                    for (int k = 0; k < 6; k++) begin
                        if (r_idx == 3'(k + 2)) r_key[k] <= byte_data;
                    end
                    r_idx <= r_idx + 3'd1;
                end
            end else if (w_timeout || r_state == COMMIT) begin
                r_idx <= 3'd0;
            end

            if (!FRAME_ALIGN) begin
                if (w_commit_ok) begin
                    r_pend     <= w_slot;
                    r_pend_mod <= r_mod_in;
                    r_kc       <= w_slot;
                    r_mod      <= r_mod_in;
                    r_strobe   <= 1'b1;
                end
            end else begin
                // Edge releases the old pending first; a same-cycle commit waits.
                if (w_frame_edge && r_pend_valid) begin
                    r_kc         <= r_pend;
                    r_mod        <= r_pend_mod;
                    r_pend_valid <= 1'b0;
                    r_strobe     <= 1'b1;
                end
                if (w_commit_ok) begin
                    r_pend       <= w_slot;
                    r_pend_mod   <= r_mod_in;
                    r_pend_valid <= 1'b1;
                end
            end
        end
    end

    assign keycode0      = r_kc[0];
    assign keycode1      = r_kc[1];
    assign keycode2      = r_kc[2];
    assign keycode3      = r_kc[3];
    assign modifier      = r_mod;
    assign report_strobe = r_strobe;
    assign rollover_drop = r_roll;
    assign timeout_err   = r_tmo;

endmodule

// File: doc/hid_keycode_writer.md
# hid_keycode_writer

Producer side of the keycode interface that the game top level consumes. Accepts a USB HID boot-keyboard report as a byte stream from the USB host software bridge. Validates the report and compacts its key slots into the four keycode registers `keycode0..keycode3` that feed the ball, reset and state-machine logic. Updates can be aligned to the VGA vertical sync, so every frame samples one coherent report.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: maximum idle gap between bytes of one report before the partial report is discarded.
- `FRAME_ALIGN`, default 1: when 1, committed reports reach the outputs only on a `frame_sync` rising edge; when 0, they reach the outputs immediately.

Ports:
- `Clk`, in, 1: system clock (50 MHz).
- `Reset`, in, 1: synchronous, active-low reset.
- `byte_valid`, in, 1: the current report byte is presented on `byte_data`.
- `byte_data`, in, 8: report byte. Index 0 = modifier, 1 = reserved, 2..7 = key slots.
- `byte_ready`, out, 1: the block accepts a byte this cycle.
- `frame_sync`, in, 1: the `vs` signal from `vga_controller`. Used only when `FRAME_ALIGN`=1.
- `keycode0`..`keycode3`, out, 8 each: compacted key slots.
- `modifier`, out, 8: modifier byte of the last applied report.
- `report_strobe`, out, 1: one-cycle pulse when the outputs take new values.
- `rollover_drop`, out, 1: one-cycle pulse when a report is discarded as ErrorRollOver.
- `timeout_err`, out, 1: one-cycle pulse when a partial report is discarded on timeout.

## Operation
- State machine: IDLE, COLLECT, COMMIT.
- Handshake:
  - A byte transfers on a cycle with `byte_valid`=1 and `byte_ready`=1.
  - `byte_ready`=1 in IDLE and COLLECT, and 0 in COMMIT.
  - `byte_valid` may stay high while `byte_ready`=0; the byte is held off, not lost.
- Byte flow:
  - IDLE: accepting a byte stores it as index 0 (modifier), sets the 3-bit byte index to 1 and moves to COLLECT.
  - COLLECT: each accepted byte is stored at the current index and the index increments. Accepting index 7 moves to COMMIT.
  - Byte 1 is ignored.
- Timeout:
  - A 16-bit gap counter runs in COLLECT and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`-1: pulse `timeout_err`, discard the partial report, return to IDLE.
  - Outputs are unchanged.
- COMMIT (exactly one cycle, then IDLE):
  - If any key byte (indices 2..7) equals 8'h01: pulse `rollover_drop` and discard the report; outputs and pending register are unchanged.
  - Otherwise, compact the nonzero key bytes in index order (2..7) into slots 0..3. Slots left unfilled are 8'h00; nonzero bytes beyond the fourth are dropped.
  - The compacted slots plus the modifier are loaded into the pending register, and `pending_valid` is set.
- Apply, `FRAME_ALIGN`=0:
  - Pending is copied to the outputs on the same edge that ends COMMIT.
  - `report_strobe` is high for the following cycle.
  - `pending_valid` never stays set.
- Apply, `FRAME_ALIGN`=1:
  - `frame_edge` = `frame_sync` & ~`frame_sync_d`, where `frame_sync_d` is a one-cycle register of `frame_sync`.
  - On a cycle with `frame_edge` and `pending_valid`: copy pending to the outputs, clear `pending_valid`, pulse `report_strobe` the next cycle.
  - Multiple commits between frame edges: the last one wins.
  - Commit and `frame_edge` in the same cycle: the frame edge applies the old pending contents (if valid). The new report is loaded into pending and waits for the next edge.
- A report with all key bytes zero is valid and clears all four keycodes (key release).

## Timing
- Reset:
  - All of these are 0: `keycode0..3`, `modifier`, pending register, `pending_valid`, byte index, gap counter, `frame_sync_d`, all pulses.
  - State is IDLE.
  - `byte_ready`=0 while `Reset`=0 and 1 in the first cycle after release.
- Reset asserted mid-report discards all collected bytes; the next accepted byte is index 0.
- Throughput: one byte per cycle plus one COMMIT bubble, so at most one report per 9 cycles.
- Latency, `FRAME_ALIGN`=0: last byte accepted on edge t; outputs valid and `report_strobe`=1 in the cycle after edge t+1.
- Latency, `FRAME_ALIGN`=1: outputs change on the first `frame_edge` cycle after COMMIT, visible the cycle after.
- Pulse lengths: `rollover_drop` is high in the cycle after COMMIT. `timeout_err` is high for exactly one cycle.

## Test plan
- Mixed key slots (`FRAME_ALIGN`=0): send 00,00,0B,00,18,00,00,00 at one byte per cycle -> 9 cycles later keycode0=0B, keycode1=18, keycode2=00, keycode3=00, `report_strobe` one cycle; `byte_ready` low for exactly one cycle.
- Overflow and release: send report keys 04,05,06,07,08,09 -> keycodes 04,05,06,07. Then send all-zero keys -> all keycodes 00.
- Rollover: send keys 01,01,01,01,01,01 after a report holding 50 -> keycode0 stays 50, `rollover_drop` pulses, `report_strobe` stays 0.
- Timeout (`TIMEOUT_CYCLES`=16): send 3 bytes, idle 16 cycles -> `timeout_err` pulses. Then a full 8-byte report with keys 4F,52 -> keycode0=4F, keycode1=52; the stale bytes have no effect.
- Frame alignment (`FRAME_ALIGN`=1): commit reports A (0B) then B (0E) before one `frame_sync` rise -> outputs unchanged until the edge, then keycode0=0E. Also commit in the same cycle as `frame_edge` -> the report applies at the next edge.
- Reset: assert `Reset`=0 after 5 bytes, release, send a full report with key 28 -> keycode0=28 and modifier equal to the new byte 0; all outputs read 0 during reset.
